// File: rtl/cpu_mem_pkg.sv
// Shared types and address decode for the CPU-bus memory responder.
package cpu_mem_pkg;

    typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_NONE} region_e;
    typedef enum logic [1:0] {IDLE, RAM_WAIT, ROM_WAIT} state_e;

    localparam logic [15:0] RAM_TOP  = 16'h1FFF;
    localparam logic [15:0] ROM_BASE = 16'h8000;

    function automatic region_e decode(input logic [15:0] a);
        if (a <= RAM_TOP)
            return REG_RAM;
        else if (a >= ROM_BASE)
            return REG_ROM;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/cpu_ram_sp.sv
// Work RAM: single port, synchronous write, asynchronous read, no reset.
module cpu_ram_sp #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Target end of the CPU bus: serves accesses from mirrored work RAM,
// a variable-latency PRG ROM port, or open bus, stalling the CPU via rdy.
module cpu_mem_responder #(
    parameter int unsigned RAM_AW      = 11,
    parameter int unsigned RAM_WAIT    = 0,
    parameter int unsigned ROM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_out,
    input  logic [7:0]  data_out,
    input  logic        ren,
    input  logic        wen,
    output logic [7:0]  data_in,
    output logic        rdy,
    output logic        rom_req,
    output logic [14:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        err
);

    // RAM_WAIT the parameter shadows the state literal, so that state is package-qualified.
    import cpu_mem_pkg::*;

    localparam int unsigned TW = $clog2(ROM_TIMEOUT + 1);

    state_e            state;
    region_e           region;
    logic [2:0]        wait_cnt;
    logic [TW-1:0]     to_cnt;
    logic [RAM_AW-1:0] ram_idx_q;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic              accept;
    logic              ram_we;

    always_comb begin
        region   = decode(addr_out);
        accept   = (state == IDLE) && rdy && (ren || wen);
        ram_we   = accept && wen && (region == REG_RAM);
        ram_addr = (state == IDLE) ? addr_out[RAM_AW-1:0] : ram_idx_q;
    end

    cpu_ram_sp #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_out),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_in   <= 8'h00;
            rdy       <= 1'b1;
            rom_req   <= 1'b0;
            rom_addr  <= '0;
            err       <= 1'b0;
            wait_cnt  <= '0;
            to_cnt    <= '0;
            ram_idx_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (ren && wen)
                            err <= 1'b1;
                        if (!wen) begin
                            case (region)
                                REG_RAM: begin
                                    if (RAM_WAIT == 0) begin
                                        data_in <= ram_rdata;
                                    end else begin
                                        rdy       <= 1'b0;
                                        state     <= cpu_mem_pkg::RAM_WAIT;
                                        wait_cnt  <= 3'(RAM_WAIT - 1);
                                        ram_idx_q <= addr_out[RAM_AW-1:0];
                                    end
                                end
                                REG_ROM: begin
                                    rom_req  <= 1'b1;
                                    rom_addr <= addr_out[14:0];
                                    rdy      <= 1'b0;
                                    state    <= ROM_WAIT;
                                    to_cnt   <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                cpu_mem_pkg::RAM_WAIT: begin
                    if (wait_cnt == '0) begin
                        data_in <= ram_rdata;
                        rdy     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ROM_WAIT: begin
                    // An ack in the expiry cycle still delivers data.
                    if (rom_ack) begin
                        data_in <= rom_data;
                        rom_req <= 1'b0;
                        rdy     <= 1'b1;
                        state   <= IDLE;
                    end else if (to_cnt == TW'(ROM_TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        rom_req <= 1'b0;
                        rdy     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: zero-wait and 3-wait-cycle instances.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] addr;
    logic [7:0]  dout;
    logic        ren, wen;
    logic [7:0]  data_in;
    logic        rdy, rom_req, err;
    logic [14:0] rom_addr;
    logic        rom_ack;
    logic [7:0]  rom_data;

    logic [15:0] addr3;
    logic [7:0]  dout3;
    logic        ren3, wen3;
    logic [7:0]  data_in3;
    logic        rdy3, rom_req3, err3;
    logic [14:0] rom_addr3;
    logic        rom_ack3;
    logic [7:0]  rom_data3;

    int checks = 0;
    int errors = 0;
    int lo;

    always #5 clk = ~clk;

    cpu_mem_responder #(.RAM_AW(11), .RAM_WAIT(0), .ROM_TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .addr_out(addr), .data_out(dout), .ren(ren), .wen(wen),
        .data_in(data_in), .rdy(rdy), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data), .err(err)
    );

    cpu_mem_responder #(.RAM_AW(11), .RAM_WAIT(3), .ROM_TIMEOUT(16)) u_dut3 (
        .clk(clk), .rst(rst), .addr_out(addr3), .data_out(dout3), .ren(ren3), .wen(wen3),
        .data_in(data_in3), .rdy(rdy3), .rom_req(rom_req3), .rom_addr(rom_addr3),
        .rom_ack(rom_ack3), .rom_data(rom_data3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        addr = '0; dout = '0; ren = 1'b0; wen = 1'b0; rom_ack = 1'b0; rom_data = '0;
        addr3 = '0; dout3 = '0; ren3 = 1'b0; wen3 = 1'b0; rom_ack3 = 1'b0; rom_data3 = '0;
        #1;
        check("rst_data_in", 32'(data_in), 32'h00);
        check("rst_rdy", 32'(rdy), 32'h1);
        check("rst_rom_req", 32'(rom_req), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write A5 to $0012 on both instances
        addr = 16'h0012; dout = 8'hA5; wen = 1'b1;
        addr3 = 16'h0012; dout3 = 8'hA5; wen3 = 1'b1;
        step();
        check("wr_rdy", 32'(rdy), 32'h1);
        check("wr_rdy3", 32'(rdy3), 32'h1);
        wen = 1'b0; wen3 = 1'b0;

        // Mirrored reads, zero wait
        ren = 1'b1; addr = 16'h0812;
        step();
        check("mirror_0812", 32'(data_in), 32'hA5);
        check("mirror_0812_rdy", 32'(rdy), 32'h1);
        addr = 16'h1812;
        step();
        check("mirror_1812", 32'(data_in), 32'hA5);
        check("mirror_1812_rdy", 32'(rdy), 32'h1);
        ren = 1'b0;

        // Three-wait-cycle RAM read
        ren3 = 1'b1; addr3 = 16'h0012;
        step();
        lo = 0;
        for (int i = 0; i < 20 && !rdy3; i++) begin
            lo++;
            step();
        end
        ren3 = 1'b0;
        check("w3_low_cycles", 32'(lo), 32'd3);
        check("w3_rdy", 32'(rdy3), 32'h1);
        check("w3_data", 32'(data_in3), 32'hA5);

        // ROM read acked after 5 cycles
        ren = 1'b1; addr = 16'hC123;
        step();
        check("rom_req_set", 32'(rom_req), 32'h1);
        check("rom_addr", 32'(rom_addr), 32'h4123);
        check("rom_rdy_low", 32'(rdy), 32'h0);
        lo = 0;
        repeat (4) begin
            if (!rdy) lo++;
            step();
        end
        rom_ack = 1'b1; rom_data = 8'h3C;
        if (!rdy) lo++;
        step();
        rom_ack = 1'b0; rom_data = 8'h00; ren = 1'b0;
        check("rom_low_cycles", 32'(lo), 32'd5);
        check("rom_ack_rdy", 32'(rdy), 32'h1);
        check("rom_ack_data", 32'(data_in), 32'h3C);
        check("rom_ack_req", 32'(rom_req), 32'h0);
        check("rom_ack_err", 32'(err), 32'h0);

        // ROM read with no ack: timeout
        ren = 1'b1; addr = 16'h8000;
        step();
        lo = 0;
        for (int i = 0; i < 40 && !rdy; i++) begin
            lo++;
            step();
        end
        ren = 1'b0;
        check("to_low_cycles", 32'(lo), 32'd16);
        check("to_rdy", 32'(rdy), 32'h1);
        check("to_data", 32'(data_in), 32'h3C);
        check("to_err", 32'(err), 32'h1);
        check("to_req", 32'(rom_req), 32'h0);

        // Stray ack in IDLE
        rom_ack = 1'b1; rom_data = 8'h77;
        step();
        rom_ack = 1'b0;
        check("idle_ack_data", 32'(data_in), 32'h3C);
        check("idle_ack_rdy", 32'(rdy), 32'h1);

        // Unmapped read, ROM write
        ren = 1'b1; addr = 16'h4015;
        step();
        check("unmapped_data", 32'(data_in), 32'h3C);
        check("unmapped_rdy", 32'(rdy), 32'h1);
        ren = 1'b0;
        wen = 1'b1; addr = 16'h9000; dout = 8'h11;
        step();
        check("romwr_req", 32'(rom_req), 32'h0);
        check("romwr_rdy", 32'(rdy), 32'h1);
        wen = 1'b0;

        // ren and wen together on the wait instance
        check("w3_err_before", 32'(err3), 32'h0);
        ren3 = 1'b1; wen3 = 1'b1; addr3 = 16'h0020; dout3 = 8'h5A;
        step();
        ren3 = 1'b0; wen3 = 1'b0;
        check("both_err", 32'(err3), 32'h1);
        check("both_rdy", 32'(rdy3), 32'h1);
        ren3 = 1'b1; addr3 = 16'h0820;
        step();
        for (int i = 0; i < 20 && !rdy3; i++) step();
        ren3 = 1'b0;
        check("both_wrote", 32'(data_in3), 32'h5A);

        // Asynchronous reset during ROM_WAIT
        ren = 1'b1; addr = 16'hC000;
        step();
        check("pre_rst_req", 32'(rom_req), 32'h1);
        check("pre_rst_rdy", 32'(rdy), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(rom_req), 32'h0);
        check("arst_rdy", 32'(rdy), 32'h1);
        check("arst_data", 32'(data_in), 32'h00);
        check("arst_err", 32'(err), 32'h0);
        ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ren = 1'b1; addr = 16'h1012;
        step();
        ren = 1'b0;
        check("post_rst_ram", 32'(data_in), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU bus: the target end of the CPU address/data/ren/wen interface.
- Decodes each CPU access and serves it from 2 KB internal work RAM (mirrored), from an external PRG ROM port with variable latency, or as open bus.
- Drives data_in and rdy back to the CPU and stalls it with rdy while a slow access is outstanding.
- Sits between the CPU core and the cartridge/ROM model in both the DUV and reference environments.

Parameters:
- RAM_AW, 11: work RAM address width (2^RAM_AW bytes); mirrored across $0000-$1FFF.
- RAM_WAIT, 0: wait cycles inserted on RAM reads (0..7).
- ROM_TIMEOUT, 16: cycles to wait for rom_ack before abandoning a ROM read.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- addr_out  in  16  CPU address
- data_out  in  8  CPU write data
- ren  in  1  CPU read strobe
- wen  in  1  CPU write strobe
- data_in  out  8  read data to CPU (registered)
- rdy  out  1  1 = bus ready / accepting; 0 = CPU must hold its request
- rom_req  out  1  ROM read request, held until acknowledged or timed out
- rom_addr  out  15  ROM byte address (addr_out[14:0])
- rom_ack  in  1  ROM data valid this cycle
- rom_data  in  8  ROM read data
- err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous): data_in=8'h00, rdy=1, rom_req=0, rom_addr=0, err=0, state=IDLE. RAM contents are not cleared. Reset mid-access abandons the access and drops rom_req immediately.
- Address decode:
  - $0000-$1FFF → RAM at index addr[RAM_AW-1:0].
  - $8000-$FFFF → ROM.
  - $2000-$7FFF → unmapped.
- Acceptance: a request is accepted at rising edge N when state=IDLE, rdy=1 and (ren|wen)=1. When not in IDLE, the bus is ignored; the CPU holds its request while rdy=0.
- ren and wen both high: treated as a write; err is set.
- States: IDLE, RAM_WAIT, ROM_WAIT.
- RAM write: memory is updated at edge N; zero wait; rdy stays 1.
- RAM read, RAM_WAIT=0: data_in is loaded at edge N; rdy stays 1.
- RAM read, RAM_WAIT=W>0:
  - At edge N: rdy goes to 0, state goes to RAM_WAIT, wait counter loads W-1.
  - At edge N+W: data_in is loaded, rdy goes to 1, state returns to IDLE.
- ROM read:
  - At edge N: rom_req=1, rom_addr=addr[14:0], rdy=0, state=ROM_WAIT, timeout counter cleared.
  - At the first edge with rom_ack=1: data_in=rom_data, rom_req=0, rdy=1, state returns to IDLE.
  - If rom_ack arrives in the same cycle as timeout expiry, the ack wins.
  - Timeout: after ROM_TIMEOUT cycles in ROM_WAIT without ack, data_in keeps its previous value (open bus), err=1, rom_req=0, rdy=1, state returns to IDLE.
- ROM write: ignored; zero wait; no rom_req.
- Unmapped read: data_in is unchanged (open bus); zero wait.
- Unmapped write: ignored; zero wait.
- rom_ack while in IDLE: ignored.
- err clears only on rst.
- Mirroring: addresses $0000, $0800, $1000 and $1800 alias to the same RAM byte.

Decomposition:
- Package cpu_mem_pkg:
  - region_e {REG_RAM, REG_ROM, REG_NONE}
  - state_e {IDLE, RAM_WAIT, ROM_WAIT}
  - constants RAM_TOP=16'h1FFF, ROM_BASE=16'h8000
  - decode function addr→region_e
- Sub-module cpu_ram_sp: 2^RAM_AW x 8 single-port RAM with synchronous write and asynchronous read. The responder registers its read data into data_in.

Test Plan:
- Write 8'hA5 to $0012, then read $0812 and $1812 with RAM_WAIT=0 → data_in=8'hA5 after each read edge; rdy never drops.
- RAM_WAIT=3, read $0012 → rdy low for exactly 3 cycles; data_in=8'hA5 at the edge rdy returns to 1.
- Read $C123, rom_ack asserted 5 cycles later with rom_data=8'h3C → rom_addr=15'h4123; rdy low 5 cycles; data_in=8'h3C; rom_req=0 after the ack edge.
- Read $8000 with no ack, ROM_TIMEOUT=16 → rdy returns 1 after 16 cycles; data_in unchanged; err=1.
- Read $4015 after a previous data_in=8'h3C → data_in stays 8'h3C with zero wait; write to $9000 → no rom_req, rdy stays 1.
- Assert rst during ROM_WAIT → rom_req=0, rdy=1, data_in=8'h00 immediately (asynchronous); a subsequent RAM read returns the pre-reset contents.
